// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline constants and front-end controller state encoding.
package pipeline_hazard_ctrl_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [4:0]  REG_ZERO  = 5'd0;

   // Front-end controller FSM encoding
   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } fsm_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and front-end control outputs between the pipeline and the controller.
interface pipeline_hazard_ctrl_if;
   import pipeline_hazard_ctrl_pkg::*;

   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       id_mdu_op;
   logic       redirect;
   logic       imem_ready;
   logic       pc_write;
   logic       enable_if_id;
   logic       flush_if_id;
   logic       bubble_id_ex;
   logic       mdu_busy;
   logic       fetch_discard;

   // Pipeline side: presents hazard info, consumes control
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_mdu_op, redirect, imem_ready,
      input  pc_write, enable_if_id, flush_if_id, bubble_id_ex, mdu_busy, fetch_discard
   );

   // Controller side
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_mdu_op, redirect, imem_ready,
      output pc_write, enable_if_id, flush_if_id, bubble_id_ex, mdu_busy, fetch_discard
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Combinational load-use detector; a load in EX feeding a source of the ID instruction.
module hazard_compare
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   output logic       load_use
);

   // r0 is hardwired, so a load targeting it never creates a dependence
   always_comb begin
      load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencing controller: redirect, load-use, imem wait and MDU occupancy.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MDU_LATENCY = 4,
   parameter int unsigned CNT_W       = 3
) (
   input logic                   clock,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave bus
);

   fsm_e             fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_pending_q, flush_pending_d;
   logic             load_use;

   hazard_compare u_hazard_compare (
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_uses_rt  (bus.id_uses_rt),
      .ex_mem_read (bus.ex_mem_read),
      .ex_rt       (bus.ex_rt),
      .load_use    (load_use)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q           <= RUN;
         cnt_q           <= '0;
         flush_pending_q <= 1'b0;
      end else begin
         fsm_q           <= fsm_d;
         cnt_q           <= cnt_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   // Next-state: priority chain in RUN, countdown in MDU_WAIT
   always_comb begin
      fsm_d           = fsm_q;
      cnt_d           = cnt_q;
      flush_pending_d = flush_pending_q;
      case (fsm_q)
         RUN: begin
            if (bus.redirect) begin
               // A second redirect while a discard is owed keeps the single flag
               if (!bus.imem_ready) flush_pending_d = 1'b1;
            end else if (load_use) begin
               // hold; MDU issue is deferred until the dependence clears
            end else if (flush_pending_q && bus.imem_ready) begin
               flush_pending_d = 1'b0;
            end else if (!bus.imem_ready) begin
               // waiting on fetch
            end else if (bus.id_mdu_op) begin
               fsm_d = MDU_WAIT;
               cnt_d = CNT_W'(MDU_LATENCY);
            end
         end
         MDU_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) fsm_d = RUN;
         end
         default: fsm_d = RUN;
      endcase
   end

   // Outputs: Mealy on state plus current hazards, forced low during reset
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.enable_if_id  = 1'b0;
      bus.flush_if_id   = 1'b0;
      bus.bubble_id_ex  = 1'b0;
      bus.mdu_busy      = 1'b0;
      bus.fetch_discard = 1'b0;
      if (!reset) begin
         case (fsm_q)
            RUN: begin
               if (bus.redirect) begin
                  bus.pc_write     = 1'b1;
                  bus.enable_if_id = 1'b1;
                  bus.flush_if_id  = 1'b1;
                  bus.bubble_id_ex = 1'b1;
               end else if (load_use) begin
                  bus.bubble_id_ex = 1'b1;
               end else if (flush_pending_q && bus.imem_ready) begin
                  bus.fetch_discard = 1'b1;
                  bus.enable_if_id  = 1'b1;
                  bus.flush_if_id   = 1'b1;
               end else if (!bus.imem_ready) begin
                  // nop into IF/ID so the ID instruction is not issued twice
                  bus.enable_if_id = 1'b1;
                  bus.flush_if_id  = 1'b1;
               end else begin
                  bus.pc_write     = 1'b1;
                  bus.enable_if_id = 1'b1;
               end
            end
            MDU_WAIT: begin
               bus.bubble_id_ex = 1'b1;
               bus.mdu_busy     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for the front-end hazard controller.
module tb_pipeline_hazard_ctrl;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl #(
      .MDU_LATENCY (4),
      .CNT_W       (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Output vector order: pc_write, enable_if_id, flush_if_id, bubble_id_ex, mdu_busy, discard
   localparam logic [5:0] ADV   = 6'b110000;
   localparam logic [5:0] ZERO  = 6'b000000;
   localparam logic [5:0] LDU   = 6'b000100;
   localparam logic [5:0] MDUW  = 6'b000110;
   localparam logic [5:0] REDIR = 6'b111100;
   localparam logic [5:0] IWAIT = 6'b011000;
   localparam logic [5:0] DISC  = 6'b011001;

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b want=%b", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {bus.pc_write, bus.enable_if_id, bus.flush_if_id, bus.bubble_id_ex,
              bus.mdu_busy, bus.fetch_discard};
   endfunction

   task automatic idle();
      bus.id_rs       = 5'd1;
      bus.id_rt       = 5'd2;
      bus.id_uses_rt  = 1'b0;
      bus.ex_mem_read = 1'b0;
      bus.ex_rt       = 5'd3;
      bus.id_mdu_op   = 1'b0;
      bus.redirect    = 1'b0;
      bus.imem_ready  = 1'b1;
   endtask

   // Sample on the falling edge, then advance past the next rising edge
   task automatic cyc(input string tag, input logic [5:0] exp);
      @(negedge clock);
      check(tag, {2'b00, outs()}, {2'b00, exp});
      @(posedge clock);
      #1;
   endtask

   // Invariants and the illegal redirect-in-MDU_WAIT condition, every cycle
   always @(negedge clock) begin
      if (!reset && total > 0) begin
         if (bus.flush_if_id && !bus.enable_if_id) check("inv_flush_en", 8'd1, 8'd0);
         if (bus.pc_write && bus.fetch_discard) check("inv_pc_disc", 8'd1, 8'd0);
         if (bus.redirect && bus.mdu_busy) check("redirect_in_mdu", 8'd1, 8'd0);
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      clock = 1'b0;
      reset = 1'b1;
      idle();
      cyc("reset_outs", ZERO);
      reset = 1'b0;
      cyc("first_adv", ADV);

      // load-use on rs, then clear
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      cyc("ldu_rs", LDU);
      idle();
      cyc("ldu_after", ADV);
      // load to r0 never stalls
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
      cyc("ldu_r0", ADV);
      // rt match only counts when rt is a source
      idle();
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
      cyc("ldu_rt", LDU);
      bus.id_uses_rt = 1'b0;
      cyc("ldu_rt_unused", ADV);
      idle();

      // MDU issue then exactly four stall cycles
      bus.id_mdu_op = 1'b1;
      cyc("mdu_issue", ADV);
      idle();
      for (int i = 0; i < 4; i++) cyc($sformatf("mdu_wait%0d", i), MDUW);
      cyc("mdu_done", ADV);

      // reset asserted mid-MDU_WAIT with cnt=2
      bus.id_mdu_op = 1'b1;
      cyc("mdu2_issue", ADV);
      idle();
      cyc("mdu2_w0", MDUW);
      cyc("mdu2_w1", MDUW);
      reset = 1'b1;
      cyc("mdu2_reset", ZERO);
      reset = 1'b0;
      cyc("mdu2_post", ADV);

      // redirect beats load-use and MDU issue
      bus.redirect = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      bus.id_mdu_op = 1'b1;
      cyc("redir_prio", REDIR);
      idle();
      cyc("redir_no_mdu", ADV);

      // redirect while fetch pending, ready three cycles later
      bus.redirect = 1'b1; bus.imem_ready = 1'b0;
      cyc("redir_wait", REDIR);
      bus.redirect = 1'b0;
      cyc("pend_w1", IWAIT);
      cyc("pend_w2", IWAIT);
      bus.imem_ready = 1'b1;
      cyc("pend_disc", DISC);
      cyc("pend_after", ADV);

      // double redirect yields a single discard
      bus.redirect = 1'b1; bus.imem_ready = 1'b0;
      cyc("dbl_r1", REDIR);
      cyc("dbl_r2", REDIR);
      bus.redirect = 1'b0; bus.imem_ready = 1'b1;
      cyc("dbl_disc", DISC);
      cyc("dbl_after", ADV);

      // plain imem wait
      bus.imem_ready = 1'b0;
      cyc("iwait0", IWAIT);
      cyc("iwait1", IWAIT);
      bus.imem_ready = 1'b1;
      cyc("iwait_done", ADV);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
